// File: rtl/au_pkg.sv
// Shared constants, codes and types for the au issue/writeback sequencer.
package au_pkg;

    localparam int W              = 24;
    localparam int FRAC           = 14;
    localparam int NREG           = 8;
    localparam int AW             = 3;
    localparam int TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } au_op_e;

    typedef enum logic [1:0] {
        YSEL_S     = 2'b00,
        YSEL_IMM   = 2'b01,
        YSEL_RECIP = 2'b10,
        YSEL_ONE   = 2'b11
    } au_ysel_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } seq_state_e;

    // S9.14 sign-magnitude: bit 23 is the sign, 14 fraction bits.
    localparam logic [W-1:0] ONE      = 24'h004000;
    localparam logic [W-1:0] NEG_ZERO = 24'h800000;

endpackage

// File: rtl/au_regfile.sv
// Operand register file: one shared write port, two operand read ports and a host read port.
module au_regfile
    import au_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] ra_r,
    output logic [W-1:0]  rd_r,
    input  logic [AW-1:0] ra_s,
    output logic [W-1:0]  rd_s,
    input  logic [AW-1:0] ra_h,
    output logic [W-1:0]  rd_h
);

    logic [W-1:0] mem [NREG];

    // NOTE: this array is small and built from flops, so clearing every entry on reset is intended; a RAM macro could not be reset this way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_r = mem[ra_r];
    assign rd_s = mem[ra_s];
    assign rd_h = mem[ra_h];

endmodule

// File: rtl/au_seq.sv
// Issue/writeback sequencer: fetches operands, launches au, waits for done
// (bounded by TIMEOUT) and writes the result back to the register file.
module au_seq
    import au_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [1:0]    instr_op,
    input  logic [1:0]    instr_ysel,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_src_r,
    input  logic [AW-1:0] instr_src_s,
    input  logic [W-1:0]  instr_imm,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          au_start,
    output logic [W-1:0]  au_r,
    output logic [W-1:0]  au_s,
    output logic [W-1:0]  au_iimm,
    output logic [1:0]    au_op_sel,
    output logic [1:0]    au_mul_y_sel,
    input  logic [W-1:0]  au_result,
    input  logic          au_done,
    input  logic          au_busy,
    output logic          seq_busy,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic          timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_e    state_q, state_d;
    logic [1:0]    op_q, ysel_q;
    logic [AW-1:0] dst_q, src_r_q, src_s_q;
    logic [W-1:0]  imm_q, result_q;
    logic [W-1:0]  r_hold_q, s_hold_q, imm_hold_q;
    logic [1:0]    op_hold_q, ysel_hold_q;
    logic [CW-1:0] cnt_q;
    logic          accept, timeout_hit, rf_we;
    logic [W-1:0]  rf_r, rf_s;

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        au_start    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = !rst;
                if (instr_valid && !rst) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!au_busy) begin
                    au_start = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (au_done) begin
                    state_d = S_WB;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = instr_valid && instr_ready;

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            ysel_q      <= '0;
            dst_q       <= '0;
            src_r_q     <= '0;
            src_s_q     <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            r_hold_q    <= '0;
            s_hold_q    <= '0;
            imm_hold_q  <= '0;
            op_hold_q   <= '0;
            ysel_hold_q <= '0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= instr_op;
                ysel_q  <= instr_ysel;
                dst_q   <= instr_dst;
                src_r_q <= instr_src_r;
                src_s_q <= instr_src_s;
                imm_q   <= instr_imm;
            end
            if (au_start) begin
                r_hold_q    <= rf_r;
                s_hold_q    <= rf_s;
                imm_hold_q  <= imm_q;
                op_hold_q   <= op_q;
                ysel_hold_q <= ysel_q;
                cnt_q       <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == S_WAIT && au_done) result_q <= au_result;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

    // Operands are shown live during ISSUE so au sees them with start, then held until the next issue.
    assign au_r         = (state_q == S_ISSUE) ? rf_r   : r_hold_q;
    assign au_s         = (state_q == S_ISSUE) ? rf_s   : s_hold_q;
    assign au_iimm      = (state_q == S_ISSUE) ? imm_q  : imm_hold_q;
    assign au_op_sel    = (state_q == S_ISSUE) ? op_q   : op_hold_q;
    assign au_mul_y_sel = (state_q == S_ISSUE) ? ysel_q : ysel_hold_q;

    assign seq_busy = (state_q != S_IDLE);
    assign wb_valid = (state_q == S_WB);
    assign wb_addr  = dst_q;
    assign rf_we    = wb_valid || (ld_en && state_q == S_IDLE);

    au_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (wb_valid ? dst_q : ld_addr),
        .wdata (wb_valid ? result_q : ld_data),
        .ra_r  (src_r_q),
        .rd_r  (rf_r),
        .ra_s  (src_s_q),
        .rd_s  (rf_s),
        .ra_h  (rd_addr),
        .rd_h  (rd_data)
    );

endmodule

// File: tb/tb_au_seq.sv
// Directed self-checking bench for au_seq; the bench itself plays the au stub.
module tb_au_seq;
    import au_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [1:0]    instr_op = '0;
    logic [1:0]    instr_ysel = '0;
    logic [AW-1:0] instr_dst = '0;
    logic [AW-1:0] instr_src_r = '0;
    logic [AW-1:0] instr_src_s = '0;
    logic [W-1:0]  instr_imm = '0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          au_start;
    logic [W-1:0]  au_r, au_s, au_iimm;
    logic [1:0]    au_op_sel, au_mul_y_sel;
    logic [W-1:0]  au_result = '0;
    logic          au_done = 1'b0;
    logic          au_busy = 1'b0;
    logic          seq_busy, wb_valid, timeout_err;
    logic [AW-1:0] wb_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int wb_cnt = 0;

    always #5 clk = ~clk;

    au_seq dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_ysel(instr_ysel), .instr_dst(instr_dst),
        .instr_src_r(instr_src_r), .instr_src_s(instr_src_s), .instr_imm(instr_imm),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .au_start(au_start), .au_r(au_r), .au_s(au_s), .au_iimm(au_iimm),
        .au_op_sel(au_op_sel), .au_mul_y_sel(au_mul_y_sel),
        .au_result(au_result), .au_done(au_done), .au_busy(au_busy),
        .seq_busy(seq_busy), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .timeout_err(timeout_err)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (au_start) start_cnt++;
        if (wb_valid) wb_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic accept(input logic [1:0] op, input logic [1:0] ysel, input logic [AW-1:0] dst,
                          input logic [AW-1:0] sr, input logic [AW-1:0] ss, input logic [W-1:0] imm);
        instr_valid = 1'b1; instr_op = op; instr_ysel = ysel;
        instr_dst = dst; instr_src_r = sr; instr_src_s = ss; instr_imm = imm;
        #1;
        check("ready_before_accept", instr_ready, 1);
        step();
        instr_valid = 1'b0;
    endtask

    // Holds au_busy for 'busy' ISSUE cycles, then checks the launch.
    task automatic issue_phase(input int busy, input logic [W-1:0] er, input logic [W-1:0] es,
                               input logic [W-1:0] eimm, input logic [1:0] eop, input logic [1:0] eysel);
        int s0;
        s0 = start_cnt;
        for (int i = 0; i < busy; i++) begin
            au_busy = 1'b1;
            #1;
            check("start_held_while_busy", au_start, 0);
            step();
        end
        au_busy = 1'b0;
        #1;
        check("start_pulse", au_start, 1);
        check("au_r", au_r, er);
        check("au_s", au_s, es);
        check("au_iimm", au_iimm, eimm);
        check("au_op_sel", au_op_sel, eop);
        check("au_mul_y_sel", au_mul_y_sel, eysel);
        check("ready_in_issue", instr_ready, 0);
        step();
        check("start_one_cycle", au_start, 0);
        check("au_r_held", au_r, er);
        check("start_count", start_cnt - s0, 1);
    endtask

    // Stub au: au_done rises in the lat-th WAIT cycle with result res.
    task automatic wait_wb(input int lat, input logic [W-1:0] res, input logic [AW-1:0] dst,
                           input bit ld_in_wait, input logic [AW-1:0] la, input logic [W-1:0] ld);
        int w0;
        w0 = wb_cnt;
        for (int i = 1; i < lat; i++) begin
            if (i == 1) begin
                check("ready_in_wait", instr_ready, 0);
                check("busy_in_wait", seq_busy, 1);
                if (ld_in_wait) begin
                    ld_en = 1'b1; ld_addr = la; ld_data = ld;
                end
            end
            step();
            ld_en = 1'b0;
        end
        au_done = 1'b1; au_result = res;
        step();
        au_done = 1'b0; au_result = '0;
        #1;
        check("wb_valid", wb_valid, 1);
        check("wb_addr", wb_addr, dst);
        check("ready_in_wb", instr_ready, 0);
        step();
        check("wb_one_cycle", wb_valid, 0);
        check("ready_after_wb", instr_ready, 1);
        check("idle_after_wb", seq_busy, 0);
        check("wb_count", wb_cnt - w0, 1);
        check("no_timeout", timeout_err, 0);
    endtask

    initial begin
        int w0;

        // Reset state
        step();
        check("ready_in_reset", instr_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("rst_au_start", au_start, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_au_r", au_r, 0);
        check("rst_au_s", au_s, 0);
        check("rst_au_iimm", au_iimm, 0);
        check("rst_op_ysel", {au_op_sel, au_mul_y_sel}, 0);
        check("rst_ready", instr_ready, 1);
        for (int a = 0; a < NREG; a++) check_reg("rst_reg", AW'(a), '0);

        // 1.0 / 2.0 = 0.5
        load(3'd1, ONE);
        load(3'd2, 24'h008000);
        accept(OP_DIV, YSEL_RECIP, 3'd3, 3'd1, 3'd2, 24'h000123);
        issue_phase(0, 24'h004000, 24'h008000, 24'h000123, 2'b11, 2'b10);
        wait_wb(24, 24'h002000, 3'd3, 1'b0, '0, '0);
        check_reg("div_pos_r3", 3'd3, 24'h002000);

        // 1.0 / -2.0 = -0.5: sign bit set in result
        load(3'd2, 24'h808000);
        accept(OP_DIV, YSEL_RECIP, 3'd3, 3'd1, 3'd2, 24'h000000);
        issue_phase(0, 24'h004000, 24'h808000, 24'h000000, 2'b11, 2'b10);
        wait_wb(24, 24'h802000, 3'd3, 1'b0, '0, '0);
        check_reg("div_neg_r3", 3'd3, 24'h802000);

        // Done exactly on the TIMEOUT-th WAIT cycle still counts as done: 1.0 + -2.0 = -1.0
        accept(OP_ADD, YSEL_S, 3'd5, 3'd1, 3'd2, 24'h000000);
        issue_phase(0, 24'h004000, 24'h808000, 24'h000000, 2'b00, 2'b00);
        wait_wb(64, 24'h804000, 3'd5, 1'b0, '0, '0);
        check_reg("boundary_r5", 3'd5, 24'h804000);

        // au_busy for 3 ISSUE cycles: start waits for the first free cycle
        accept(OP_MUL, YSEL_IMM, 3'd6, 3'd3, 3'd1, 24'h00ABCD);
        issue_phase(3, 24'h802000, 24'h004000, 24'h00ABCD, 2'b10, 2'b01);
        wait_wb(5, 24'h802000, 3'd6, 1'b0, '0, '0);
        check_reg("busy_r6", 3'd6, 24'h802000);

        // Load and accept in the same cycle: ISSUE reads the new (negative zero) value;
        // a load during WAIT is dropped.
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = NEG_ZERO;
        accept(OP_SUB, YSEL_S, 3'd4, 3'd1, 3'd2, 24'h000000);
        ld_en = 1'b0;
        issue_phase(0, 24'h004000, NEG_ZERO, 24'h000000, 2'b01, 2'b00);
        wait_wb(6, ONE, 3'd4, 1'b1, 3'd2, 24'h00ABCD);
        check_reg("ld_wait_ignored_r2", 3'd2, NEG_ZERO);
        check_reg("sub_r4", 3'd4, ONE);

        // au never completes: abort after 64 WAIT cycles, no writeback
        w0 = wb_cnt;
        accept(OP_DIV, YSEL_RECIP, 3'd3, 3'd1, 3'd4, 24'h000000);
        issue_phase(0, 24'h004000, ONE, 24'h000000, 2'b11, 2'b10);
        for (int i = 1; i < 64; i++) step();
        check("timeout_still_waiting", seq_busy, 1);
        check("timeout_not_yet", timeout_err, 0);
        step();
        check("timeout_err_set", timeout_err, 1);
        check("timeout_idle", seq_busy, 0);
        check("timeout_ready", instr_ready, 1);
        check("timeout_no_wb", wb_cnt - w0, 0);
        check_reg("timeout_r3_kept", 3'd3, 24'h802000);
        step();
        check("timeout_sticky", timeout_err, 1);

        // rst in WAIT abandons the op; a late au_done is ignored
        w0 = wb_cnt;
        accept(OP_ADD, YSEL_S, 3'd7, 3'd1, 3'd1, 24'h000000);
        issue_phase(0, 24'h004000, 24'h004000, 24'h000000, 2'b00, 2'b00);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        au_done = 1'b1; au_result = 24'h008000;
        step();
        au_done = 1'b0; au_result = '0;
        step();
        check("rst_wait_no_wb", wb_cnt - w0, 0);
        check("rst_wait_idle", seq_busy, 0);
        check("rst_wait_timeout_clr", timeout_err, 0);
        for (int a = 0; a < NREG; a++) check_reg("rst_wait_reg", AW'(a), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
